// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline hazard logic: register numbering,
// stall FSM encoding and the source-register match helper.
package pipeline_pkg;

  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] REG_ZERO = '0;

  localparam logic ST_RUN   = 1'b0;
  localparam logic ST_HOLD1 = 1'b1;

  typedef enum logic {
    RUN   = ST_RUN,
    HOLD1 = ST_HOLD1
  } state_t;

  // True when destination rd feeds a source operand of the ID instruction.
  // $zero is hardwired, so it never creates a dependency.
  function automatic logic reads_reg(input logic [REG_W-1:0] rd,
                                     input logic [REG_W-1:0] rs,
                                     input logic [REG_W-1:0] rt,
                                     input logic             use_rt);
    return (rd != REG_ZERO) && ((rd == rs) || (use_rt && (rd == rt)));
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; synchronous reset.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/hazard_control.sv
// Stall/flush controller for the 5-stage pipeline: catches the hazards that
// forwarding cannot cover and counts stall cycles and flushes.
//
//   state | meaning
//   RUN   | no pending stall; stalls come only from live hazard terms
//   HOLD1 | second stall cycle owed to a branch waiting on a load in EX
module hazard_control
  import pipeline_pkg::*;
#(
  parameter int COUNTER_WIDTH = 32,
  parameter int BRANCH_IN_ID  = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [REG_W-1:0]         registerRsID,
  input  logic [REG_W-1:0]         registerRtID,
  input  logic                     useRtID,
  input  logic                     branchID,
  input  logic                     branchTakenID,
  input  logic                     jumpID,
  input  logic [REG_W-1:0]         registerRdEX,
  input  logic                     regWriteEX,
  input  logic                     memReadEX,
  input  logic [REG_W-1:0]         registerRdMEM,
  input  logic                     memReadMEM,
  output logic                     pcWrite,
  output logic                     ifIdWrite,
  output logic                     idExBubble,
  output logic                     ifIdFlush,
  output logic                     stall,
  output logic [COUNTER_WIDTH-1:0] stallCycles,
  output logic [COUNTER_WIDTH-1:0] flushCount
);

  localparam logic BR_EN = (BRANCH_IN_ID != 0);

  state_t state;
  logic   dep_ex;
  logic   dep_mem;
  logic   load_use;
  logic   br_alu;
  logic   br_load_ex;
  logic   br_load_mem;
  logic   hazard;

  assign dep_ex  = reads_reg(registerRdEX,  registerRsID, registerRtID, useRtID);
  assign dep_mem = reads_reg(registerRdMEM, registerRsID, registerRtID, useRtID);

  assign load_use    = memReadEX && dep_ex;
  assign br_alu      = BR_EN && branchID && regWriteEX && !memReadEX && dep_ex;
  assign br_load_ex  = BR_EN && branchID && memReadEX && dep_ex;
  assign br_load_mem = BR_EN && branchID && memReadMEM && dep_mem;

  assign hazard = (state == HOLD1) || load_use || br_alu || br_load_ex || br_load_mem;

  // Flush waits while stalled: the branch compare uses operands not yet valid.
  assign stall      = !reset && hazard;
  assign pcWrite    = !stall;
  assign ifIdWrite  = !stall;
  assign idExBubble = stall;
  assign ifIdFlush  = !reset && !stall && (jumpID || (branchID && branchTakenID));

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= RUN;
    end else begin
      case (state)
        RUN:     state <= br_load_ex ? HOLD1 : RUN;
        HOLD1:   state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

  sat_counter #(.WIDTH(COUNTER_WIDTH)) u_stall_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (stall),
    .count (stallCycles)
  );

  sat_counter #(.WIDTH(COUNTER_WIDTH)) u_flush_cnt (
    .clock (clock),
    .reset (reset),
    .inc   (ifIdFlush),
    .count (flushCount)
  );

endmodule

// File: tb/tb_hazard_control.sv
// Bench for hazard_control: directed pipeline scenarios plus random traffic,
// all checked every cycle against a behavioural model of the hazard rules.
module tb_hazard_control;

  logic       clock = 1'b0;
  logic       reset;
  logic [4:0] rs, rt, rd_ex, rd_mem;
  logic       use_rt, br, br_taken, jmp, rw_ex, mr_ex, mr_mem;

  logic        pc_write, ifid_write, bubble, flush, stall;
  logic [31:0] stall_cnt, flush_cnt;
  logic        s_pc_write, s_ifid_write, s_bubble, s_flush, s_stall;
  logic [2:0]  s_stall_cnt, s_flush_cnt;

  int tests = 0;
  int fails = 0;

  // model state
  bit      m_owed;
  longint  m_stalls;
  longint  m_flushes;
  bit      e_stall, e_flush;

  always #5 clock = ~clock;

  hazard_control #(.COUNTER_WIDTH(32), .BRANCH_IN_ID(1)) dut (
    .clock(clock), .reset(reset),
    .registerRsID(rs), .registerRtID(rt), .useRtID(use_rt),
    .branchID(br), .branchTakenID(br_taken), .jumpID(jmp),
    .registerRdEX(rd_ex), .regWriteEX(rw_ex), .memReadEX(mr_ex),
    .registerRdMEM(rd_mem), .memReadMEM(mr_mem),
    .pcWrite(pc_write), .ifIdWrite(ifid_write), .idExBubble(bubble),
    .ifIdFlush(flush), .stall(stall),
    .stallCycles(stall_cnt), .flushCount(flush_cnt)
  );

  hazard_control #(.COUNTER_WIDTH(3), .BRANCH_IN_ID(1)) dut_sat (
    .clock(clock), .reset(reset),
    .registerRsID(rs), .registerRtID(rt), .useRtID(use_rt),
    .branchID(br), .branchTakenID(br_taken), .jumpID(jmp),
    .registerRdEX(rd_ex), .regWriteEX(rw_ex), .memReadEX(mr_ex),
    .registerRdMEM(rd_mem), .memReadMEM(mr_mem),
    .pcWrite(s_pc_write), .ifIdWrite(s_ifid_write), .idExBubble(s_bubble),
    .ifIdFlush(s_flush), .stall(s_stall),
    .stallCycles(s_stall_cnt), .flushCount(s_flush_cnt)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic bit depends(input logic [4:0] rd);
    return rd != 5'd0 && (rd == rs || (use_rt && rd == rt));
  endfunction

  function automatic longint sat(input longint v, input longint maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  // Compare every output of both instances against the model, then advance it.
  task automatic check_all();
    bit lu, b_alu, b_lex, b_lmem;
    lu     = mr_ex && depends(rd_ex);
    b_alu  = br && rw_ex && !mr_ex && depends(rd_ex);
    b_lex  = br && mr_ex && depends(rd_ex);
    b_lmem = br && mr_mem && depends(rd_mem);
    e_stall = !reset && (m_owed || lu || b_alu || b_lex || b_lmem);
    e_flush = !reset && !e_stall && (jmp || (br && br_taken));

    chk("stall",       stall,      e_stall);
    chk("pcWrite",     pc_write,   !e_stall);
    chk("ifIdWrite",   ifid_write, !e_stall);
    chk("idExBubble",  bubble,     e_stall);
    chk("ifIdFlush",   flush,      e_flush);
    chk("stallCycles", stall_cnt,  sat(m_stalls, 64'hFFFF_FFFF));
    chk("flushCount",  flush_cnt,  sat(m_flushes, 64'hFFFF_FFFF));
    chk("sat.stall",   s_stall,    e_stall);
    chk("sat.flush",   s_flush,    e_flush);
    chk("sat.stallCycles", s_stall_cnt, sat(m_stalls, 7));
    chk("sat.flushCount",  s_flush_cnt, sat(m_flushes, 7));

    // A branch waiting on a load in EX owes exactly one extra cycle; no chaining.
    if (reset) begin
      m_owed = 0; m_stalls = 0; m_flushes = 0;
    end else begin
      m_owed = !m_owed && b_lex;
      m_stalls  += longint'(e_stall);
      m_flushes += longint'(e_flush);
    end
  endtask

  task automatic sample(); @(negedge clock); check_all(); endtask
  task automatic adv();    @(posedge clock); #1; endtask
  task automatic tick();   sample(); adv(); endtask

  task automatic idle();
    rs = 5'd1; rt = 5'd2; use_rt = 0; br = 0; br_taken = 0; jmp = 0;
    rd_ex = 5'd0; rw_ex = 0; mr_ex = 0; rd_mem = 5'd0; mr_mem = 0;
  endtask

  task automatic do_reset();
    reset = 1; idle(); tick(); reset = 0;
  endtask

  initial begin
    m_owed = 0; m_stalls = 0; m_flushes = 0;
    // reset held with a live load-use hazard on the inputs
    idle(); reset = 1; mr_ex = 1; rd_ex = 5'd8; rs = 5'd8;
    adv();
    sample();
    chk("reset.stall", stall, 1'b0);
    chk("reset.pcWrite", pc_write, 1'b1);
    chk("reset.stallCycles", stall_cnt, 32'd0);
    adv();
    reset = 0;

    // load-use: lw $8 in EX, add rs=8 in ID
    do_reset();
    idle(); mr_ex = 1; rd_ex = 5'd8; rs = 5'd8;
    sample(); chk("lu.stall", stall, 1'b1); chk("lu.pcWrite", pc_write, 1'b0);
    chk("lu.bubble", bubble, 1'b1); adv();
    idle();
    sample(); chk("lu.release", stall, 1'b0); chk("lu.stallCycles", stall_cnt, 32'd1); adv();

    // branch after ALU result: add $9 in EX, beq rt=9
    do_reset();
    idle(); rw_ex = 1; rd_ex = 5'd9; br = 1; br_taken = 1; rt = 5'd9; use_rt = 1; rs = 5'd3;
    sample(); chk("bralu.stall", stall, 1'b1); chk("bralu.noflush", flush, 1'b0); adv();
    idle(); br = 1; br_taken = 1; rt = 5'd9; use_rt = 1; rs = 5'd3;
    sample(); chk("bralu.flush", flush, 1'b1); adv();
    idle();
    sample(); chk("bralu.flushCount", flush_cnt, 32'd1);
    chk("bralu.stallCycles", stall_cnt, 32'd1); adv();

    // branch after load: two stall cycles (HOLD1 plus load now in MEM)
    do_reset();
    idle(); mr_ex = 1; rd_ex = 5'd10; br = 1; rs = 5'd10;
    sample(); chk("brld.stall1", stall, 1'b1); adv();
    idle(); mr_mem = 1; rd_mem = 5'd10; br = 1; rs = 5'd10;
    sample(); chk("brld.stall2", stall, 1'b1); adv();
    idle(); br = 1;
    sample(); chk("brld.run", stall, 1'b0); chk("brld.stallCycles", stall_cnt, 32'd2); adv();

    // pending HOLD1 stalls on its own even with quiet inputs
    idle(); mr_ex = 1; rd_ex = 5'd11; br = 1; rt = 5'd11; use_rt = 1;
    tick();
    idle();
    sample(); chk("hold1.alone", stall, 1'b1); adv();
    sample(); chk("hold1.done", stall, 1'b0); adv();

    // register zero and rt not read
    idle(); mr_ex = 1; rd_ex = 5'd0; rs = 5'd0;
    sample(); chk("zero.nostall", stall, 1'b0); adv();
    idle(); mr_ex = 1; rd_ex = 5'd8; rt = 5'd8; use_rt = 0;
    sample(); chk("nort.nostall", stall, 1'b0); adv();

    // jr waiting on a load: stall wins, flush follows
    idle(); jmp = 1; mr_ex = 1; rd_ex = 5'd8; rs = 5'd8;
    sample(); chk("jr.stall", stall, 1'b1); chk("jr.noflush", flush, 1'b0); adv();
    idle(); jmp = 1; rs = 5'd8;
    sample(); chk("jr.flush", flush, 1'b1); adv();

    // reset while HOLD1 is pending
    do_reset();
    idle(); mr_ex = 1; rd_ex = 5'd12; br = 1; rs = 5'd12;
    tick();
    idle(); reset = 1;
    sample(); chk("rsthold.stall", stall, 1'b0); adv();
    reset = 0;
    sample(); chk("rsthold.after", stall, 1'b0); chk("rsthold.stallCycles", stall_cnt, 32'd0);
    chk("rsthold.flushCount", flush_cnt, 32'd0); adv();

    // saturation of the 3-bit instance
    do_reset();
    idle(); mr_ex = 1; rd_ex = 5'd8; rs = 5'd8;
    repeat (10) tick();
    idle();
    sample(); chk("sat.stick7", s_stall_cnt, 3'd7); chk("sat.wide10", stall_cnt, 32'd10); adv();

    // random traffic over a small register set to provoke collisions
    for (int i = 0; i < 3000; i++) begin
      reset    = ($urandom_range(0, 99) < 2);
      rs       = 5'($urandom_range(0, 3));
      rt       = 5'($urandom_range(0, 3));
      rd_ex    = 5'($urandom_range(0, 3));
      rd_mem   = 5'($urandom_range(0, 3));
      use_rt   = 1'($urandom_range(0, 1));
      br       = ($urandom_range(0, 99) < 40);
      br_taken = 1'($urandom_range(0, 1));
      jmp      = ($urandom_range(0, 99) < 15);
      rw_ex    = 1'($urandom_range(0, 1));
      mr_ex    = ($urandom_range(0, 99) < 30);
      mr_mem   = ($urandom_range(0, 99) < 30);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
